// File: rtl/tcam_rule_writer.sv
// tcam_rule_writer: expands one ternary rule into unary-encoded BRAM TCAM words by read-modify-write
module tcam_rule_writer #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 36,
    parameter int L = 4,
    parameter int N = 4,
    localparam int SW_WIDTH = WIDTH / N,
    localparam int SA_DEPTH = DEPTH / L,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(L),
    localparam int BW = $clog2(SA_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [AW-1:0]             req_addr,
    input  logic [WIDTH-1:0]          req_patt,
    input  logic [WIDTH-1:0]          req_mask,
    input  logic                      req_del,
    output logic                      busy,
    output logic                      done,
    output logic [SW_WIDTH-1:0]       ram_addr,
    output logic [L-1:0]              ram_wen,
    output logic [N*SA_DEPTH-1:0]     ram_din,
    input  logic [L*N*SA_DEPTH-1:0]   ram_dout
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state, state_n;
    logic [SW_WIDTH:0] cnt, cnt_n;
    logic [AW-1:0] addr_q;
    logic [WIDTH-1:0] patt_q, mask_q;
    logic del_q;
    logic [LW-1:0] lay;
    logic [BW-1:0] bsel;
    logic [SA_DEPTH-1:0] oh, rd;
    logic last, hit;
    assign lay  = addr_q[AW-1:BW];
    assign bsel = addr_q[BW-1:0];
    assign oh   = SA_DEPTH'(1) << bsel;
    assign last = cnt == (SW_WIDTH+1)'((1 << SW_WIDTH) - 1);
    // next state: one read and one write per sub-address, then a single done cycle
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: if (req_valid) begin
                state_n = RD;
                cnt_n = '0;
            end
            RD: state_n = WR;
            WR: if (last) state_n = DONE;
                else begin
                    state_n = RD;
                    cnt_n = cnt + 1'b1;
                end
            default: state_n = IDLE;
        endcase
    end
    // state, request latch and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            patt_q <= '0;
            mask_q <= '0;
            del_q <= 1'b0;
            req_ready <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            ram_addr <= '0;
            ram_wen <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (req_valid && req_ready) begin
                addr_q <= req_addr;
                patt_q <= req_patt;
                mask_q <= req_mask;
                del_q <= req_del;
            end
            req_ready <= state_n == IDLE;
            busy <= state_n != IDLE;
            done <= state_n == DONE;
            ram_addr <= cnt_n[SW_WIDTH-1:0];
            ram_wen <= (state_n == WR) ? L'(1) << lay : '0;
        end
    end
    // write data: keep every other entry's bit, set the target bit only where the subword matches
    always_comb begin
        ram_din = '0;
        rd = '0;
        hit = 1'b0;
        if (state == WR)
            for (int j = 0; j < N; j++) begin
                rd = ram_dout[(int'(lay) * N + j) * SA_DEPTH +: SA_DEPTH];
                hit = !del_q && (((cnt[SW_WIDTH-1:0] ^ patt_q[j*SW_WIDTH +: SW_WIDTH]) & ~mask_q[j*SW_WIDTH +: SW_WIDTH]) == '0);
                ram_din[j*SA_DEPTH +: SA_DEPTH] = (rd & ~oh) | (hit ? oh : '0);
            end
    end
endmodule

// File: tb/tb_tcam_rule_writer.sv
// tb_tcam_rule_writer: random and directed rule writes checked against a rule-table model of the TCAM
module tb_tcam_rule_writer;
    localparam int DEPTH = 16, WIDTH = 8, L = 2, N = 2, SW = 4, SA = 8, T = 33;
    logic clk = 0, rst_n = 1;
    logic req_valid = 0, req_del = 0;
    logic [3:0] req_addr = 0;
    logic [7:0] req_patt = 0, req_mask = 0;
    logic req_ready, busy, done;
    logic [3:0] ram_addr;
    logic [1:0] ram_wen;
    logic [15:0] ram_din;
    logic [31:0] ram_dout;
    logic [7:0] mem [L][N][16];
    logic [7:0] dout_r [L][N];
    bit init_done = 0;
    int n_chk = 0, n_pass = 0;
    int phase = 0, acc_cnt = 0, done_cnt = 0, cyc = 0, acc_cyc = 0;
    logic [3:0] m_addr = 0;
    logic [7:0] m_patt = 0, m_mask = 0;
    logic m_del = 0;
    bit t_valid [16];
    bit [7:0] t_patt [16], t_mask [16];

    tcam_rule_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .L(L), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_patt(req_patt), .req_mask(req_mask), .req_del(req_del),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wen(ram_wen),
        .ram_din(ram_din), .ram_dout(ram_dout));

    always #5 clk = ~clk;

    // BRAM array: one-cycle registered read, per-layer write
    always @(posedge clk) begin
        if (!init_done) begin
            for (int l = 0; l < L; l++)
                for (int j = 0; j < N; j++) begin
                    dout_r[l][j] <= '0;
                    for (int a = 0; a < 16; a++) mem[l][j][a] <= '0;
                end
            init_done <= 1;
        end else
            for (int l = 0; l < L; l++)
                for (int j = 0; j < N; j++) begin
                    dout_r[l][j] <= mem[l][j][ram_addr];
                    if (ram_wen[l]) mem[l][j][ram_addr] <= ram_din[j*SA +: SA];
                end
    end

    always_comb begin
        ram_dout = '0;
        for (int l = 0; l < L; l++)
            for (int j = 0; j < N; j++) ram_dout[(l*N+j)*SA +: SA] = dout_r[l][j];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit sub_match(input int a, input bit [7:0] p, input bit [7:0] m, input int j);
        bit [3:0] pj, mj, aj;
        pj = p[j*SW +: SW];
        mj = m[j*SW +: SW];
        aj = 4'(a);
        return ((aj ^ pj) & ~mj) == 4'd0;
    endfunction

    // transaction model: a walk lasts T cycles from accept; the rule table commits at its end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase = 0;
        else begin
            cyc++;
            if (phase == 0) begin
                if (req_valid) begin
                    m_addr = req_addr; m_patt = req_patt; m_mask = req_mask; m_del = req_del;
                    phase = 1; acc_cnt++; acc_cyc = cyc;
                end
            end else if (phase == T) begin
                phase = 0;
                t_valid[m_addr] = !m_del;
                t_patt[m_addr] = m_patt;
                t_mask[m_addr] = m_mask;
                done_cnt++;
            end else phase++;
        end
    end

    // per-cycle output comparison against the transaction model
    always @(negedge clk) begin
        logic [1:0] ew;
        logic [7:0] v;
        int a;
        ew = (phase >= 2 && phase <= 32 && phase % 2 == 0) ? 2'(1 << m_addr[3]) : 2'b00;
        chk("ready", {31'b0, req_ready}, {31'b0, phase == 0});
        chk("busy", {31'b0, busy}, {31'b0, phase != 0});
        chk("done", {31'b0, done}, {31'b0, phase == T});
        chk("wen", {30'b0, ram_wen}, {30'b0, ew});
        if (phase >= 1 && phase <= 32) chk("addr", {28'b0, ram_addr}, (phase - 1) / 2);
        if (ew != 0) begin
            a = (phase - 1) / 2;
            for (int j = 0; j < N; j++) begin
                v = mem[m_addr[3]][j][a];
                v[m_addr[2:0]] = !m_del && sub_match(a, m_patt, m_mask, j);
                chk("din", {24'b0, ram_din[j*SA +: SA]}, {24'b0, v});
            end
        end
    end

    function automatic int lookup_arr(input bit [7:0] key);
        bit h;
        for (int l = 0; l < L; l++)
            for (int b = 0; b < SA; b++) begin
                h = 1;
                for (int j = 0; j < N; j++) h &= mem[l][j][key[j*SW +: SW]][b];
                if (h) return l * SA + b;
            end
        return -1;
    endfunction

    function automatic int lookup_mdl(input bit [7:0] key);
        for (int e = 0; e < DEPTH; e++)
            if (t_valid[e] && ((key ^ t_patt[e]) & ~t_mask[e]) == 8'd0) return e;
        return -1;
    endfunction

    function automatic int bit_count(input int l, input int j, input int b);
        int c = 0;
        for (int a = 0; a < 16; a++) c += int'(mem[l][j][a][b]);
        return c;
    endfunction

    task automatic check_array(input int skip);
        int mism = 0;
        bit e;
        for (int l = 0; l < L; l++)
            for (int j = 0; j < N; j++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < SA; b++)
                        if (l * SA + b != skip) begin
                            e = t_valid[l*SA+b] && sub_match(a, t_patt[l*SA+b], t_mask[l*SA+b], j);
                            if (mem[l][j][a][b] !== e) mism++;
                        end
        chk("array", mism, 0);
    endtask

    task automatic start(input logic [3:0] a, input logic [7:0] p, input logic [7:0] m, input logic d);
        int s, n;
        @(negedge clk); #1;
        req_addr = a; req_patt = p; req_mask = m; req_del = d; req_valid = 1;
        s = acc_cnt; n = 0;
        while (acc_cnt == s && n < 200) begin @(posedge clk); #1; n++; end
        chk("accept", acc_cnt - s, 1);
        req_valid = 0;
    endtask

    task automatic walk_len();
        int n = 0, nd = 0;
        @(negedge clk);
        while (busy && n < 200) begin n++; nd += int'(done); @(negedge clk); end
        chk("busy_len", n, T);
        chk("done_pulses", nd, 1);
    endtask

    task automatic issue(input logic [3:0] a, input logic [7:0] p, input logic [7:0] m, input logic d);
        start(a, p, m, d);
        walk_len();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int s, n, a_cyc;
        logic [7:0] mk, k;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        repeat (4) @(negedge clk);
        check_array(-1);
        // exact insert
        issue(4'd5, 8'hA3, 8'h00, 0);
        check_array(-1);
        chk("u0_a3_b5", {31'b0, mem[0][0][3][5]}, 1);
        chk("u1_aA_b5", {31'b0, mem[0][1][10][5]}, 1);
        chk("u0_b5_cnt", bit_count(0, 0, 5) + bit_count(0, 1, 5), 2);
        chk("lk_a3", lookup_arr(8'hA3), 5);
        chk("lk_a2", lookup_arr(8'hA2), -1);
        chk("mdl_a3", lookup_mdl(8'hA3), 5);
        // ternary insert
        issue(4'd9, 8'h30, 8'h0F, 0);
        check_array(-1);
        chk("l1_u0_b1_cnt", bit_count(1, 0, 1), 16);
        chk("l1_u1_b1_cnt", bit_count(1, 1, 1), 1);
        chk("l1_u1_a3_b1", {31'b0, mem[1][1][3][1]}, 1);
        chk("lk_3c", lookup_arr(8'h3C), 9);
        // overwrite and delete
        issue(4'd5, 8'h11, 8'h00, 0);
        check_array(-1);
        chk("lk_a3_ow", lookup_arr(8'hA3), -1);
        chk("lk_11", lookup_arr(8'h11), 5);
        issue(4'd5, 8'h00, 8'h00, 1);
        check_array(-1);
        chk("b5_cleared", bit_count(0, 0, 5) + bit_count(0, 1, 5), 0);
        chk("lk_3c_keep", lookup_arr(8'h3C), 9);
        // back-pressure: second request held valid during the first walk
        start(4'd12, 8'h5A, 8'hF0, 0);
        a_cyc = acc_cyc;
        req_addr = 4'd3; req_patt = 8'hC7; req_mask = 8'h01; req_del = 0; req_valid = 1;
        s = acc_cnt; n = 0;
        while (acc_cnt == s && n < 200) begin @(posedge clk); #1; n++; end
        chk("bp_accept", acc_cnt - s, 1);
        req_valid = 0;
        chk("bp_gap", acc_cyc - a_cyc, T + 1);
        walk_len();
        check_array(-1);
        chk("lk_c6", lookup_arr(8'hC6), 3);
        // randomized rules
        for (int r = 0; r < 14; r++) begin
            for (int j = 0; j < N; j++) begin
                n = int'($urandom_range(0, 2));
                mk[j*SW +: SW] = (n == 0) ? 4'h0 : (n == 1) ? 4'hF : 4'($urandom);
            end
            issue(4'($urandom_range(0, 15)), 8'($urandom), mk, $urandom_range(0, 3) == 0);
            check_array(-1);
            for (int q = 0; q < 6; q++) begin
                k = 8'($urandom);
                chk("lookup", lookup_arr(k), lookup_mdl(k));
            end
        end
        // mid-walk reset, then re-issue
        start(4'd14, 8'h96, 8'h00, 0);
        repeat (10) @(negedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        chk("rst_idle", {30'b0, busy, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        repeat (2) @(negedge clk);
        check_array(14);
        issue(4'd14, 8'h96, 8'h00, 0);
        check_array(-1);
        chk("lk_96", lookup_arr(8'h96), lookup_mdl(8'h96));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
